// File: rtl/udma_filter_chan_seq.sv
`default_nettype none
// ============================================================================
//  Module   : udma_filter_chan_seq
//  Purpose  : L2 address sequencer for one uDMA filter operand/result channel
//             (LINEAR, SLIDING, CIRCULAR and 2D address patterns).
//  Option   : UDMA_FILTER_CHAN_SEQ_ABORT_EN adds the abort_i port.
//  Revision : 1.0 - initial release
// ============================================================================
module udma_filter_chan_seq #(
    parameter int L2_AWIDTH_NOAL = 15,
    parameter int TRANS_SIZE     = 15
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      cfg_start_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_start_addr_i,
    input  logic [1:0]                cfg_datasize_i,
    input  logic [1:0]                cfg_mode_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len0_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len1_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len2_i,
    output logic                      req_o,
    output logic [L2_AWIDTH_NOAL-1:0] addr_o,
    output logic [1:0]                datasize_o,
    output logic                      last_o,
    input  logic                      gnt_i,
`ifdef UDMA_FILTER_CHAN_SEQ_ABORT_EN
    input  logic                      abort_i,
`endif
    output logic                      busy_o,
    output logic                      done_o
);

    localparam logic [1:0] c_mode_linear   = 2'd0;
    localparam logic [1:0] c_mode_sliding  = 2'd1;
    localparam logic [1:0] c_mode_circular = 2'd2;
    localparam logic [1:0] c_mode_2d       = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [1:0]                r_mode;
    logic [1:0]                r_datasize;
    logic [TRANS_SIZE-1:0]     r_len0;
    logic [TRANS_SIZE-1:0]     r_len1;
    logic [TRANS_SIZE-1:0]     r_len2;
    logic [TRANS_SIZE-1:0]     r_inner;
    logic [TRANS_SIZE-1:0]     r_outer;
    logic [L2_AWIDTH_NOAL-1:0] r_addr;
    logic [L2_AWIDTH_NOAL-1:0] r_line;

    logic                      w_abort;
    logic                      w_load;
    logic                      w_fire;
    logic                      w_cfg_empty;
    logic                      w_inner_end;
    logic                      w_last;
    logic [TRANS_SIZE-1:0]     w_len0_m1;
    logic [TRANS_SIZE-1:0]     w_len1_m1;
    logic [TRANS_SIZE-1:0]     w_inner_lim;
    logic [L2_AWIDTH_NOAL-1:0] w_inc;
    logic [L2_AWIDTH_NOAL-1:0] w_line_step;

`ifdef UDMA_FILTER_CHAN_SEQ_ABORT_EN
    assign w_abort = abort_i;
`else
    assign w_abort = 1'b0;
`endif

    assign w_cfg_empty = (cfg_len0_i == '0) ||
                         ((cfg_mode_i != c_mode_linear) && (cfg_len1_i == '0));

    assign w_len0_m1 = r_len0 - TRANS_SIZE'(1);
    assign w_len1_m1 = r_len1 - TRANS_SIZE'(1);

    // r_inner walks len0 items in LINEAR/2D and len1 items in SLIDING/CIRCULAR
    assign w_inner_lim = ((r_mode == c_mode_linear) || (r_mode == c_mode_2d)) ? w_len0_m1 : w_len1_m1;
    assign w_inner_end = (r_inner == w_inner_lim);

    always_comb begin
        w_last = 1'b0;
        case (r_mode)
            c_mode_linear:   w_last = (r_inner == w_len0_m1);
            c_mode_sliding:  w_last = (r_outer == w_len0_m1) && w_inner_end;
            c_mode_circular: w_last = (r_outer == w_len0_m1);
            default:         w_last = (r_outer == w_len1_m1) && w_inner_end;
        endcase
    end

    always_comb begin
        w_inc = '0;
        case (r_datasize)
            2'd0:    w_inc[0] = 1'b1;
            2'd1:    w_inc[1] = 1'b1;
            default: w_inc[2] = 1'b1;
        endcase
    end

    // Step applied to the window/row base when the inner counter wraps;
    // CIRCULAR uses zero so the wrap returns to the start address.
    always_comb begin
        w_line_step = '0;
        case (r_mode)
            c_mode_sliding: w_line_step = w_inc;
            c_mode_2d:      w_line_step = L2_AWIDTH_NOAL'(r_len2);
            default:        w_line_step = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_fire      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_start_i) begin
                    w_load      = 1'b1;
                    w_state_nxt = w_cfg_empty ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (gnt_i) begin
                    w_fire = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (!w_abort && cfg_start_i) begin
                    w_load      = 1'b1;
                    w_state_nxt = w_cfg_empty ? ST_DONE : ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_mode     <= '0;
            r_datasize <= '0;
            r_len0     <= '0;
            r_len1     <= '0;
            r_len2     <= '0;
            r_inner    <= '0;
            r_outer    <= '0;
            r_addr     <= '0;
            r_line     <= '0;
        end else if (w_load) begin
            r_mode     <= cfg_mode_i;
            r_datasize <= cfg_datasize_i;
            r_len0     <= cfg_len0_i;
            r_len1     <= cfg_len1_i;
            r_len2     <= cfg_len2_i;
            r_inner    <= '0;
            r_outer    <= '0;
            r_addr     <= cfg_start_addr_i;
            r_line     <= cfg_start_addr_i;
        end else if (w_fire) begin
            if (w_inner_end) begin
                r_inner <= '0;
                r_line  <= r_line + w_line_step;
                r_addr  <= r_line + w_line_step;
            end else begin
                r_inner <= r_inner + TRANS_SIZE'(1);
                r_addr  <= r_addr + w_inc;
            end
            // CIRCULAR counts every beat on the outer counter; others count wraps
            if (w_inner_end || (r_mode == c_mode_circular)) begin
                r_outer <= r_outer + TRANS_SIZE'(1);
            end
        end
    end

    assign req_o      = (r_state == ST_RUN) && !w_abort;
    assign last_o     = (r_state == ST_RUN) && w_last;
    assign busy_o     = (r_state == ST_RUN);
    assign done_o     = (r_state == ST_DONE);
    assign addr_o     = r_addr;
    assign datasize_o = r_datasize;

endmodule
`default_nettype wire

// File: tb/tb_udma_filter_chan_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_udma_filter_chan_seq
//  Purpose  : Self-checking bench for udma_filter_chan_seq (directed table,
//             randomized transfers against an address-list model, corners).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_udma_filter_chan_seq;

    localparam int c_aw = 15;
    localparam int c_ts = 15;
    localparam int c_nr = 40;

    logic            clk_i = 1'b0;
    logic            rstn_i = 1'b0;
    logic            cfg_start_i = 1'b0;
    logic [c_aw-1:0] cfg_start_addr_i = '0;
    logic [1:0]      cfg_datasize_i = '0;
    logic [1:0]      cfg_mode_i = '0;
    logic [c_ts-1:0] cfg_len0_i = '0;
    logic [c_ts-1:0] cfg_len1_i = '0;
    logic [c_ts-1:0] cfg_len2_i = '0;
    logic            gnt_i = 1'b0;
    logic            req_o;
    logic [c_aw-1:0] addr_o;
    logic [1:0]      datasize_o;
    logic            last_o;
    logic            busy_o;
    logic            done_o;
`ifdef UDMA_FILTER_CHAN_SEQ_ABORT_EN
    logic            abort_i = 1'b0;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk_i = ~clk_i;

    udma_filter_chan_seq #(.L2_AWIDTH_NOAL(c_aw), .TRANS_SIZE(c_ts)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .cfg_start_i      (cfg_start_i),
        .cfg_start_addr_i (cfg_start_addr_i),
        .cfg_datasize_i   (cfg_datasize_i),
        .cfg_mode_i       (cfg_mode_i),
        .cfg_len0_i       (cfg_len0_i),
        .cfg_len1_i       (cfg_len1_i),
        .cfg_len2_i       (cfg_len2_i),
        .req_o            (req_o),
        .addr_o           (addr_o),
        .datasize_o       (datasize_o),
        .last_o           (last_o),
        .gnt_i            (gnt_i),
`ifdef UDMA_FILTER_CHAN_SEQ_ABORT_EN
        .abort_i          (abort_i),
`endif
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    typedef struct {
        logic [1:0]      mode;
        logic [c_aw-1:0] base;
        logic [1:0]      ds;
        logic [c_ts-1:0] l0;
        logic [c_ts-1:0] l1;
        logic [c_ts-1:0] l2;
        int              pct;
        bit              poke;
        bit              chain;
        int              n;
        int unsigned     a[8];
    } vec_t;

    vec_t tbl[8];
    vec_t rv[c_nr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Expected address list straight from the pattern formulas
    task automatic model(input vec_t v, output int unsigned q[$]);
        longint unsigned inc;
        longint unsigned b;
        q = {};
        inc = (v.ds >= 2'd2) ? 4 : ((v.ds == 2'd1) ? 2 : 1);
        b = longint'(v.base);
        case (v.mode)
            2'd0: for (int i = 0; i < int'(v.l0); i++)
                      q.push_back(int'((b + i * inc) & 32'h7FFF));
            2'd1: for (int k = 0; k < int'(v.l0); k++)
                      for (int j = 0; j < int'(v.l1); j++)
                          q.push_back(int'((b + (k + j) * inc) & 32'h7FFF));
            2'd2: if (v.l1 != 0)
                      for (int i = 0; i < int'(v.l0); i++)
                          q.push_back(int'((b + (i % int'(v.l1)) * inc) & 32'h7FFF));
            default: for (int r = 0; r < int'(v.l1); r++)
                         for (int j = 0; j < int'(v.l0); j++)
                             q.push_back(int'((b + r * longint'(v.l2) + j * inc) & 32'h7FFF));
        endcase
    endtask

    task automatic drive_start(input vec_t v);
        cfg_mode_i       = v.mode;
        cfg_start_addr_i = v.base;
        cfg_datasize_i   = v.ds;
        cfg_len0_i       = v.l0;
        cfg_len1_i       = v.l1;
        cfg_len2_i       = v.l2;
        cfg_start_i      = 1'b1;
    endtask

    // Called at the negedge where a start is being driven; returns at the
    // negedge of the done cycle (optionally driving the next start there).
    task automatic check_xfer(input string nm, input int unsigned exp[$], input vec_t v,
                              input bit poke, input bit chain, input vec_t nxt);
        int  idx = 0;
        int  n = exp.size();
        int  budget = 0;
        bit  granted;
        bit  poked = 0;
        @(negedge clk_i);
        cfg_start_i = 1'b0;
        while (idx < n && budget < 400) begin
            chk($sformatf("%s req b%0d", nm, idx), 32'(req_o), 32'd1);
            chk($sformatf("%s addr b%0d", nm, idx), 32'(addr_o), exp[idx]);
            chk($sformatf("%s last b%0d", nm, idx), 32'(last_o), 32'(idx == n - 1));
            chk($sformatf("%s busy b%0d", nm, idx), 32'(busy_o), 32'd1);
            chk($sformatf("%s done b%0d", nm, idx), 32'(done_o), 32'd0);
            chk($sformatf("%s ds b%0d", nm, idx), 32'(datasize_o), 32'(v.ds));
            gnt_i = ($urandom_range(99) < v.pct);
            if (poke && !poked && idx == 1) begin
                cfg_start_i      = 1'b1;
                cfg_mode_i       = 2'($urandom_range(3));
                cfg_start_addr_i = 15'($urandom_range(32767));
                cfg_len0_i       = 15'($urandom_range(1, 9));
                cfg_len1_i       = 15'($urandom_range(1, 9));
                poked = 1;
            end
            granted = gnt_i;
            @(negedge clk_i);
            cfg_start_i = 1'b0;
            gnt_i = 1'b0;
            if (granted) idx++;
            budget++;
        end
        if (budget >= 400) chk({nm, " timeout"}, 32'(idx), 32'(n));
        chk({nm, " done pulse"}, 32'(done_o), 32'd1);
        chk({nm, " done req"}, 32'(req_o), 32'd0);
        chk({nm, " done busy"}, 32'(busy_o), 32'd0);
        if (chain) drive_start(nxt);
    endtask

    task automatic idle_check(input string nm);
        @(negedge clk_i);
        chk({nm, " idle req"}, 32'(req_o), 32'd0);
        chk({nm, " idle done"}, 32'(done_o), 32'd0);
        chk({nm, " idle busy"}, 32'(busy_o), 32'd0);
    endtask

    task automatic run_list(input string nm, input vec_t v[$], input bit use_tbl);
        int unsigned q[$];
        drive_start(v[0]);
        for (int i = 0; i < v.size(); i++) begin
            bit ch;
            if (use_tbl) begin
                q = {};
                for (int k = 0; k < v[i].n; k++) q.push_back(v[i].a[k]);
            end else begin
                model(v[i], q);
            end
            ch = v[i].chain && (i + 1 < v.size());
            check_xfer($sformatf("%s%0d", nm, i), q, v[i], v[i].poke && q.size() >= 3, ch,
                       v[(i + 1 < v.size()) ? i + 1 : i]);
            if (!ch && i + 1 < v.size()) begin
                idle_check($sformatf("%s%0d", nm, i));
                drive_start(v[i + 1]);
            end
        end
    endtask

    initial begin
        vec_t lst[$];
        int unsigned q[$];
        tbl[0] = '{2'd0, 15'h100,  2'd2, 15'd4, 15'd0, 15'd0,     100, 1'b0, 1'b1, 4, '{32'h100, 32'h104, 32'h108, 32'h10C, 0, 0, 0, 0}};
        tbl[1] = '{2'd1, 15'h0,    2'd0, 15'd3, 15'd2, 15'd0,     100, 1'b0, 1'b1, 6, '{0, 1, 1, 2, 2, 3, 0, 0}};
        tbl[2] = '{2'd2, 15'h20,   2'd1, 15'd5, 15'd2, 15'd0,     100, 1'b1, 1'b0, 5, '{32'h20, 32'h22, 32'h20, 32'h22, 32'h20, 0, 0, 0}};
        tbl[3] = '{2'd3, 15'h40,   2'd0, 15'd2, 15'd2, 15'h10,    50,  1'b0, 1'b0, 4, '{32'h40, 32'h41, 32'h50, 32'h51, 0, 0, 0, 0}};
        tbl[4] = '{2'd0, 15'h123,  2'd0, 15'd0, 15'd7, 15'd0,     100, 1'b0, 1'b1, 0, '{0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[5] = '{2'd1, 15'h0,    2'd0, 15'd3, 15'd0, 15'd0,     100, 1'b0, 1'b1, 0, '{0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[6] = '{2'd0, 15'h7FF8, 2'd3, 15'd4, 15'd0, 15'd0,     100, 1'b0, 1'b1, 4, '{32'h7FF8, 32'h7FFC, 0, 4, 0, 0, 0, 0}};
        tbl[7] = '{2'd3, 15'h10,   2'd1, 15'd3, 15'd1, 15'h100,   70,  1'b0, 1'b0, 3, '{32'h10, 32'h12, 32'h14, 0, 0, 0, 0, 0}};

        repeat (3) @(negedge clk_i);
        chk("rst req", 32'(req_o), 32'd0);
        chk("rst addr", 32'(addr_o), 32'd0);
        chk("rst ds", 32'(datasize_o), 32'd0);
        chk("rst last", 32'(last_o), 32'd0);
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst done", 32'(done_o), 32'd0);
        rstn_i = 1'b1;
        idle_check("post-rst");

        lst = {};
        for (int i = 0; i < 8; i++) lst.push_back(tbl[i]);
        run_list("dir", lst, 1'b1);
        idle_check("dir-end");

        // Asynchronous reset in the middle of a 2D transfer
        drive_start('{2'd3, 15'h40, 2'd0, 15'd2, 15'd3, 15'h10, 100, 1'b0, 1'b0, 0, '{0, 0, 0, 0, 0, 0, 0, 0}});
        @(negedge clk_i);
        cfg_start_i = 1'b0;
        gnt_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("mid2d addr", 32'(addr_o), 32'h50);
        rstn_i = 1'b0;
        gnt_i = 1'b0;
        #1;
        chk("arst req", 32'(req_o), 32'd0);
        chk("arst addr", 32'(addr_o), 32'd0);
        chk("arst ds", 32'(datasize_o), 32'd0);
        chk("arst last", 32'(last_o), 32'd0);
        chk("arst busy", 32'(busy_o), 32'd0);
        chk("arst done", 32'(done_o), 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        idle_check("arst-rel");
        lst = {};
        lst.push_back(tbl[3]);
        run_list("after-rst", lst, 1'b1);
        idle_check("after-rst");

`ifdef UDMA_FILTER_CHAN_SEQ_ABORT_EN
        drive_start('{2'd0, 15'h200, 2'd2, 15'd6, 15'd0, 15'd0, 100, 1'b0, 1'b0, 0, '{0, 0, 0, 0, 0, 0, 0, 0}});
        @(negedge clk_i);
        cfg_start_i = 1'b0;
        gnt_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("abort pre addr", 32'(addr_o), 32'h208);
        abort_i = 1'b1;
        #1;
        chk("abort req mask", 32'(req_o), 32'd0);
        @(negedge clk_i);
        abort_i = 1'b0;
        gnt_i = 1'b0;
        chk("abort busy", 32'(busy_o), 32'd0);
        chk("abort done", 32'(done_o), 32'd0);
        idle_check("abort");
        drive_start('{2'd0, 15'h0, 2'd0, 15'd0, 15'd0, 15'd0, 100, 1'b0, 1'b0, 0, '{0, 0, 0, 0, 0, 0, 0, 0}});
        @(negedge clk_i);
        chk("abort-done pulse", 32'(done_o), 32'd1);
        drive_start('{2'd0, 15'h300, 2'd0, 15'd3, 15'd0, 15'd0, 100, 1'b0, 1'b0, 0, '{0, 0, 0, 0, 0, 0, 0, 0}});
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        cfg_start_i = 1'b0;
        chk("abort-wins req", 32'(req_o), 32'd0);
        chk("abort-wins busy", 32'(busy_o), 32'd0);
        chk("abort-wins done", 32'(done_o), 32'd0);
        idle_check("abort-wins");
`endif

        for (int i = 0; i < c_nr; i++) begin
            rv[i].mode  = 2'($urandom_range(3));
            rv[i].base  = 15'($urandom_range(32767));
            rv[i].ds    = 2'($urandom_range(3));
            rv[i].l0    = 15'($urandom_range(0, 5));
            rv[i].l1    = 15'($urandom_range(0, 4));
            rv[i].l2    = 15'($urandom_range(32767));
            rv[i].pct   = $urandom_range(30, 100);
            rv[i].poke  = ($urandom_range(3) == 0);
            rv[i].chain = ($urandom_range(1) == 1);
            rv[i].n     = 0;
            for (int k = 0; k < 8; k++) rv[i].a[k] = 0;
        end
        lst = {};
        for (int i = 0; i < c_nr; i++) lst.push_back(rv[i]);
        model(rv[0], q);
        run_list("rnd", lst, 1'b0);
        idle_check("rnd-end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
